// File: rtl/conv_pkg.sv
// Shared constants and types for the custom convolution execute stage (conv_mac_unit).
package conv_pkg;

   localparam logic [3:0] ALU_CONV    = 4'b1111;
   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   localparam int CONV_LANES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } conv_state_t;

   // Keep a single-lane build legal: a 1-bit index is still needed.
   function automatic int idx_width(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   localparam int CONV_IDX_W = idx_width(CONV_LANES);

endpackage

// File: rtl/conv_mac_lane.sv
// Combinational lane select and signed multiply-accumulate for conv_mac_unit.
module conv_mac_lane #(
   parameter int XLEN   = 32,
   parameter int LANE_W = 8,
   parameter int LANES  = 4,
   parameter int IDX_W  = 2
) (
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [IDX_W-1:0] idx,
   input  logic [XLEN-1:0]  acc,
   output logic [XLEN-1:0]  acc_next
);

   logic signed [LANE_W-1:0]   a_lane;
   logic signed [LANE_W-1:0]   b_lane;
   logic signed [2*LANE_W-1:0] prod;
   logic        [XLEN-1:0]     prod_x;

   assign a_lane = a[idx*LANE_W +: LANE_W];
   assign b_lane = b[idx*LANE_W +: LANE_W];
   assign prod   = a_lane * b_lane;
   assign prod_x = {{(XLEN-2*LANE_W){prod[2*LANE_W-1]}}, prod};

   // Accumulator wraps modulo 2^XLEN; no overflow flag.
   assign acc_next = acc + prod_x;

endmodule

// File: rtl/conv_mac_unit.sv
// Multi-cycle dot-product execute stage; stalls fetch while the MACs run.
// Optional fused ReLU on the result when CONV_RELU_EN is defined.
//
// state | meaning
// IDLE  | waiting for start with alu_control == ALU_CONV
// BUSY  | one MAC per cycle over lanes 0..LANES-1
// DONE  | result/done/regwrite presented for one cycle, fetch released
module conv_mac_unit
   import conv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int LANE_W = 8,
   parameter int LANES  = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            regwrite
);

   localparam int IDX_W = idx_width(LANES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES-1);

   conv_state_t     state;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] acc_next;
   logic [XLEN-1:0] final_val;
   logic [IDX_W-1:0] idx;
   logic            accept;

   assign accept = start & (alu_control == ALU_CONV) & (state == IDLE);
   assign stall  = accept | (state == BUSY);

   conv_mac_lane #(
      .XLEN   (XLEN),
      .LANE_W (LANE_W),
      .LANES  (LANES),
      .IDX_W  (IDX_W)
   ) u_lane (
      .a        (op_a),
      .b        (op_b),
      .idx      (idx),
      .acc      (acc),
      .acc_next (acc_next)
   );

`ifdef CONV_RELU_EN
   assign final_val = acc_next[XLEN-1] ? '0 : acc_next;
`else
   assign final_val = acc_next;
`endif

   // result/done are loaded on the last MAC so they are visible during DONE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         op_a     <= '0;
         op_b     <= '0;
         acc      <= '0;
         idx      <= '0;
         done     <= 1'b0;
         regwrite <= 1'b0;
         result   <= '0;
      end else begin
         done     <= 1'b0;
         regwrite <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_a  <= src1;
                  op_b  <= src2;
                  acc   <= '0;
                  idx   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               acc <= acc_next;
               idx <= idx + 1'b1;
               if (idx == IDX_LAST) begin
                  result   <= final_val;
                  done     <= 1'b1;
                  regwrite <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_mac_unit.sv
// Self-checking bench for conv_mac_unit: vector table plus scoreboard queue.
module tb_conv_mac_unit;

   localparam int XLEN  = 32;
   localparam int LANES = 4;

   logic            clock;
   logic            reset_n;
   logic            start;
   logic [3:0]      alu_control;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;
   logic            regwrite;

   int checks;
   int failures;
   logic [XLEN-1:0] sb_q[$];
   logic [XLEN-1:0] last_exp;

   typedef struct {
      logic [31:0] s1;
      logic [31:0] s2;
      logic [3:0]  alu;
      logic [31:0] exp;
   } vec_t;

   conv_mac_unit #(.XLEN(XLEN), .LANE_W(8), .LANES(LANES)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .alu_control (alu_control),
      .src1        (src1),
      .src2        (src2),
      .stall       (stall),
      .done        (done),
      .result      (result),
      .regwrite    (regwrite)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef CONV_RELU_EN
      return x[31] ? 32'h0 : x;
`else
      return x;
`endif
   endfunction

   function automatic logic [31:0] dot_model(input logic [31:0] a, input logic [31:0] b);
      int sum;
      byte sa;
      byte sb;
      sum = 0;
      for (int i = 0; i < LANES; i++) begin
         sa = a[i*8 +: 8];
         sb = b[i*8 +: 8];
         sum += int'(sa) * int'(sb);
      end
      return 32'(sum);
   endfunction

   // Scoreboard: every done pulse retires the oldest expected result.
   always @(negedge clock) begin
      if (reset_n === 1'b1 && done === 1'b1) begin
         if (sb_q.size() == 0) chk("unexpected_done", 32'(done), 32'h0);
         else chk("result", result, sb_q.pop_front());
         chk("regwrite_eq_done", 32'(regwrite), 32'(done));
      end
   end

   task automatic do_op(input logic [31:0] s1, input logic [31:0] s2,
                        input logic [3:0] alu, input logic [31:0] exp);
      logic acc_exp;
      acc_exp = (alu == 4'b1111);
      @(posedge clock); #1;
      start = 1'b1; src1 = s1; src2 = s2; alu_control = alu;
      @(negedge clock);
      chk("stall_c0", 32'(stall), 32'(acc_exp));
      if (acc_exp) sb_q.push_back(exp);
      @(posedge clock); #1;
      start = 1'b0; src1 = $urandom; src2 = $urandom; alu_control = 4'h0;
      for (int k = 1; k <= LANES + 1; k++) begin
         @(negedge clock);
         chk("stall_cyc", 32'(stall), 32'(acc_exp && k <= LANES));
         chk("done_cyc", 32'(done), 32'(acc_exp && k == LANES + 1));
      end
      if (acc_exp) last_exp = exp;
      else chk("result_held", result, last_exp);
   endtask

   vec_t vecs[8];

   initial begin
      checks = 0; failures = 0; last_exp = '0;
      vecs[0] = '{32'h04030201, 32'h01010101, 4'b1111, 32'h0000000A};
      vecs[1] = '{32'hFFFFFFFF, 32'h02020202, 4'b1111, 32'hFFFFFFF8};
      vecs[2] = '{32'h80808080, 32'h80808080, 4'b1111, 32'h00010000};
      vecs[3] = '{32'h12345678, 32'h11111111, 4'b0010, 32'h00000000};
      vecs[4] = '{32'h7F7F7F7F, 32'h81818181, 4'b1111, 32'hFFFF03FC};
      vecs[5] = '{32'h01FF7F80, 32'h02030405, 4'b1111, 32'hFFFFFF7B};
      vecs[6] = '{32'h00000000, 32'h7F7F7F7F, 4'b1111, 32'h00000000};
      vecs[7] = '{32'h04030201, 32'h01010101, 4'b0000, 32'h00000000};

      reset_n = 1'b0; start = 1'b0; alu_control = 4'h0; src1 = '0; src2 = '0;
      repeat (2) @(negedge clock);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_regwrite", 32'(regwrite), 32'h0);
      chk("rst_result", result, 32'h0);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++)
         do_op(vecs[i].s1, vecs[i].s2, vecs[i].alu, relu(vecs[i].exp));

      for (int i = 0; i < 4; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom; rb = $urandom;
         do_op(ra, rb, 4'b1111, relu(dot_model(ra, rb)));
      end

      // Starts during BUSY and DONE are ignored; next accept in cycle 6.
      @(posedge clock); #1;
      start = 1'b1; src1 = 32'h04030201; src2 = 32'h01010101; alu_control = 4'b1111;
      @(negedge clock); chk("busy_c0_stall", 32'(stall), 32'h1);
      sb_q.push_back(relu(32'h0000000A));
      @(posedge clock); #1; start = 1'b0;
      @(posedge clock); #1; start = 1'b1; src1 = 32'h7F7F7F7F;
      @(negedge clock); chk("busy_c2_stall", 32'(stall), 32'h1);
      @(posedge clock); #1; start = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1; start = 1'b1; src2 = 32'h01010101;
      @(negedge clock);
      chk("busy_c5_done", 32'(done), 32'h1);
      chk("busy_c5_stall", 32'(stall), 32'h0);
      @(posedge clock); #1;
      @(negedge clock); chk("busy_c6_accept", 32'(stall), 32'h1);
      sb_q.push_back(relu(32'h000001FC));
      @(posedge clock); #1; start = 1'b0; alu_control = 4'h0;
      for (int k = 1; k <= LANES + 1; k++) begin
         @(negedge clock);
         chk("b2b_done", 32'(done), 32'(k == LANES + 1));
      end

      // Asynchronous reset in cycle 3 aborts the instruction.
      @(posedge clock); #1;
      start = 1'b1; src1 = 32'h05050505; src2 = 32'h03030303; alu_control = 4'b1111;
      @(posedge clock); #1; start = 1'b0; alu_control = 4'h0;
      @(posedge clock);
      @(posedge clock); #2;
      chk("pre_rst_stall", 32'(stall), 32'h1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_stall", 32'(stall), 32'h0);
      chk("mid_rst_done", 32'(done), 32'h0);
      chk("mid_rst_result", result, 32'h0);
      last_exp = '0;
      @(negedge clock); reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         chk("post_rst_no_done", 32'(done), 32'h0);
      end
      do_op(32'h05050505, 32'h03030303, 4'b1111, relu(32'h0000003C));

      repeat (2) @(negedge clock);
      chk("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
